// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmit path, and meant to be reused by
// the receive path:
//   - FSM state encoding for the serializer (IDLE/START/DATA/STOP)
//   - 8N1 frame constants (start bit level, stop bit level, data bit count)
//   - symbol_edge_time(): clock cycles per serial bit, truncated
// -----------------------------------------------------------------------------
package uart_pkg;

    // State encoding, kept as plain constants so other blocks can decode a
    // captured state value without depending on the enum type.
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DATA  = 2'd2;
    localparam logic [1:0] STATE_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        START = STATE_START,
        DATA  = STATE_DATA,
        STOP  = STATE_STOP
    } uart_state_t;

    // 8N1 framing
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Cycles per bit. Integer truncation, so the real baud rate is slightly
    // higher than requested when the ratio is not exact.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous circular FIFO with first-word fall-through read data.
// DEPTH must be a power of two (pointers wrap naturally), WIDTH is the entry
// width.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data; ignored while full
//   pop             read request; ignored while empty
//   rdata           head entry (valid whenever empty is low)
//   full, empty     occupancy flags derived from count
//   count           number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even if the same edge pops; this keeps
    // ready a pure function of the registered count.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_transmitter.sv
// -----------------------------------------------------------------------------
// uart_fifo_transmitter
// Buffered 8N1 UART transmitter, LSB first. Bytes enter a FIFO through a
// valid/ready handshake and are serialized back-to-back onto sout.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (aborts any frame)
//   data_in         byte to send, sampled only when accepted
//   data_in_valid   data_in is valid
//   data_in_ready   FIFO not full
//   sout            registered serial line, idle high
//   busy            serializer active or FIFO non-empty
//   count           FIFO occupancy (excludes the byte in the shifter)
// -----------------------------------------------------------------------------
module uart_fifo_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        sout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int SET    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int BAUD_W = $clog2(SET) + 1;
    localparam int BIT_W  = $clog2(DATA_BITS);

    uart_state_t       state,    state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [BIT_W-1:0]  bit_idx,  bit_n;
    logic [7:0]        shift,    shift_n;
    logic              sout_n;
    logic              baud_done;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_in_valid),
        .wdata (data_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign data_in_ready = !fifo_full;
    assign busy          = (state != IDLE) || !fifo_empty;
    assign baud_done     = (baud_cnt == BAUD_W'(SET - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            sout     <= STOP_BIT;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            sout     <= sout_n;
        end
    end

    // sout is driven one edge ahead: each state loads the level of the next
    // bit on its terminal baud count, so every bit is held exactly SET cycles.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        shift_n  = shift;
        sout_n   = sout;
        fifo_pop = 1'b0;

        case (state)
            IDLE: begin
                sout_n = STOP_BIT;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_rdata;
                    sout_n   = START_BIT;
                    baud_n   = '0;
                    state_n  = START;
                end
            end

            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    sout_n  = shift[0];
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        sout_n  = STOP_BIT;
                        state_n = STOP;
                    end else begin
                        shift_n = shift >> 1;
                        sout_n  = shift[1];
                        bit_n   = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    // Chain straight into the next start bit so queued
                    // frames go out with no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_rdata;
                        sout_n   = START_BIT;
                        state_n  = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                sout_n  = STOP_BIT;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_transmitter
// dut_a: default parameters (434 cycles/bit), single-byte frame check.
// dut_b: 1 MHz / 100 kbaud (10 cycles/bit), all queueing scenarios plus random
// traffic against a queue/timestamp reference model; a serial monitor decodes
// dut_b's line and compares against the scoreboard of accepted bytes.
// -----------------------------------------------------------------------------
module tb_uart_fifo_transmitter;

    localparam int SET_A = 434;
    localparam int SET_B = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       sout_a, sout_b;
    logic       busy_a, busy_b;
    logic [2:0] count_a, count_b;

    int checks = 0;
    int errors = 0;

    // Reference model for dut_b: bytes waiting in the FIFO and the cycle at
    // which the frame currently on the line ends.
    int         mcyc  = 0;
    bit         m_act = 1'b0;
    int         m_end = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         starts[$];
    bit         mon_en = 1'b1;

    always #5 clk = ~clk;

    uart_fifo_transmitter dut_a (
        .clk           (clk),
        .rst_n         (rst_a),
        .data_in       (data_a),
        .data_in_valid (valid_a),
        .data_in_ready (ready_a),
        .sout          (sout_a),
        .busy          (busy_a),
        .count         (count_a)
    );

    uart_fifo_transmitter #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_b),
        .data_in       (data_b),
        .data_in_valid (valid_b),
        .data_in_ready (ready_b),
        .sout          (sout_b),
        .busy          (busy_b),
        .count         (count_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock of dut_b stimulus; the model advances on the same edge and
    // the handshake/occupancy outputs are compared at the following negedge.
    task automatic step(input logic v, input logic [7:0] d, output bit acc);
        bit rdy;
        valid_b = v;
        data_b  = d;
        @(posedge clk);
        mcyc++;
        rdy = (mq.size() != DEPTH);
        if (m_act && mcyc == m_end) begin
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                m_end = mcyc + 10 * SET_B;
            end else begin
                m_act = 1'b0;
            end
        end else if (!m_act && mq.size() > 0) begin
            void'(mq.pop_front());
            m_act = 1'b1;
            m_end = mcyc + 10 * SET_B;
        end
        acc = v && rdy;
        if (acc) begin
            mq.push_back(d);
            sb.push_back(d);
        end
        @(negedge clk);
        chk("b_ready", int'(ready_b), int'(mq.size() != DEPTH));
        chk("b_count", int'(count_b), mq.size());
        chk("b_busy",  int'(busy_b),  int'(m_act || mq.size() > 0));
    endtask

    task automatic push_b(input logic [7:0] d);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 2000) begin
            step(1'b1, d, acc);
            n++;
        end
        if (!acc) chk("push_b_timeout_ready", int'(ready_b), 1);
        valid_b = 1'b0;
    endtask

    task automatic drain(input string name);
        bit acc;
        int n = 0;
        while ((m_act || mq.size() > 0) && n < 20000) begin
            step(1'b0, 8'h00, acc);
            n++;
        end
        repeat (3) step(1'b0, 8'h00, acc);
        chk({name, "_idle"}, int'(busy_b), 0);
        chk({name, "_all_received"}, sb.size(), 0);
    endtask

    // Serial receiver for dut_b: mid-bit sampling from the falling edge.
    initial begin : monitor_b
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (mon_en && rst_b === 1'b1 && sout_b === 1'b0) begin
                starts.push_back(mcyc);
                repeat (SET_B / 2) @(negedge clk);
                chk("rx_start_bit", int'(sout_b), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (SET_B) @(negedge clk);
                    rx[i] = sout_b;
                end
                repeat (SET_B) @(negedge clk);
                chk("rx_stop_bit", int'(sout_b), 1);
                chk("rx_frame_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("rx_byte", int'(rx), int'(sb.pop_front()));
            end
        end
    end

    initial begin : stim
        bit         acc;
        int         since;
        int         n_acc;
        int         idx;
        logic [9:0] fa;
        logic [7:0] rxa;

        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst_a_sout",  int'(sout_a),  1);
        chk("rst_a_busy",  int'(busy_a),  0);
        chk("rst_a_count", int'(count_a), 0);
        chk("rst_a_ready", int'(ready_a), 1);
        chk("rst_b_sout",  int'(sout_b),  1);
        chk("rst_b_busy",  int'(busy_b),  0);
        chk("rst_b_count", int'(count_b), 0);
        chk("rst_b_ready", int'(ready_b), 1);
        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        // ---- dut_a: 0x7A at default baud ----
        fa = {1'b1, 8'h7A, 1'b0};
        valid_a = 1'b1; data_a = 8'h7A;
        step(1'b0, 8'h00, acc);
        valid_a = 1'b0;
        chk("a_busy_after_accept", int'(busy_a), 1);
        chk("a_count_after_accept", int'(count_a), 1);
        step(1'b0, 8'h00, acc);
        chk("a_sout_fall_latency", int'(sout_a), 0);
        since = 0;
        repeat (SET_A / 2) begin step(1'b0, 8'h00, acc); since++; end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a_bit%0d", i), int'(sout_a), int'(fa[i]));
            if (i >= 1 && i <= 8) rxa[i-1] = sout_a;
            if (i < 9) repeat (SET_A) begin step(1'b0, 8'h00, acc); since++; end
        end
        chk("a_rx_byte", int'(rxa), 122);
        while (busy_a && since < 5000) begin step(1'b0, 8'h00, acc); since++; end
        chk("a_busy_fall_time", since, 10 * SET_A);
        chk("a_line_idle", int'(sout_a), 1);

        // ---- dut_b: 0xC3 frame length ----
        push_b(8'hC3);
        step(1'b0, 8'h00, acc);
        chk("b_sout_fall_latency", int'(sout_b), 0);
        since = 0;
        while (busy_b && since < 300) begin step(1'b0, 8'h00, acc); since++; end
        chk("b_frame_len", since, 10 * SET_B);
        drain("c3");

        // ---- burst with valid held high ----
        starts.delete();
        idx = 1; n_acc = 0;
        repeat (20) begin
            if (ready_b) n_acc++;
            step(1'b1, 8'(idx), acc);
            if (acc && idx < 8) idx++;
        end
        valid_b = 1'b0;
        chk("burst_accepted", n_acc, 5);
        chk("burst_ready_low", int'(ready_b), 0);
        drain("burst");
        chk("burst_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++)
            chk("burst_gap", starts[i] - starts[i-1], 10 * SET_B);

        // ---- push landing on the edge a STOP completes and pops ----
        push_b(8'h3C); push_b(8'h5A); push_b(8'hE1);
        chk("pp_count_before", int'(count_b), 2);
        while (mcyc < m_end - 1) step(1'b0, 8'h00, acc);
        step(1'b1, 8'h0F, acc);
        valid_b = 1'b0;
        chk("pp_count_after", int'(count_b), 2);
        drain("pushpop");

        // ---- wrap-around: 4 rounds of 3 bytes ----
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) push_b(8'(8'hA0 + r * 3 + j));
            drain("wrap");
        end
        chk("wrap_count", int'(count_b), 0);

        // ---- random traffic ----
        repeat (1500) step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), acc);
        valid_b = 1'b0;
        drain("random");

        // ---- reset during bit 3 of 0x55 with two bytes queued ----
        mon_en = 1'b0;
        push_b(8'h55); push_b(8'h11); push_b(8'h22);
        while (mcyc < m_end - 10 * SET_B + 4 * SET_B + SET_B / 2) step(1'b0, 8'h00, acc);
        chk("pre_reset_bit3", int'(sout_b), 0);
        #1;
        rst_b = 1'b0;
        #1;
        chk("midrst_sout",  int'(sout_b),  1);
        chk("midrst_count", int'(count_b), 0);
        chk("midrst_busy",  int'(busy_b),  0);
        chk("midrst_ready", int'(ready_b), 1);
        mq.delete(); sb.delete(); m_act = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        mon_en = 1'b1;
        repeat (150) begin
            step(1'b0, 8'h00, acc);
            chk("post_reset_line", int'(sout_b), 1);
        end
        push_b(8'h96);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_transmitter.md
Name: uart_fifo_transmitter

Overview:
Buffered UART transmit side. Accepts bytes over a valid/ready handshake into a small FIFO and serializes them onto the serial line. Frame format is 8N1, LSB first. Pairs with the existing UART receive path and with the serial-line bench harness, and gives the CPU's serial TX a queue so software can burst several bytes without polling between them.

Parameters:
ClockFreq, 50_000_000, input clock frequency in Hz
BaudRate, 115_200, serial bit rate
FifoDepth, 4, queued bytes excluding the byte in the shifter; must be a power of 2, ≥2
(derived) SymbolEdgeTime = ClockFreq / BaudRate (integer truncation), e.g. 434 cycles per bit at the defaults

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low (asserted when 0)
DataIn  input  8  byte to transmit
DataInValid  input  1  DataIn is valid
DataInReady  output  1  FIFO can accept; high when not full
SOut  output  1  serial line, idle high; registered
Busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty
Count  output  $clog2(FifoDepth)+1  FIFO occupancy

Behaviour:
- Reset (Reset=0) acts asynchronously and overrides everything:
  - SOut=1, Busy=0, Count=0, DataInReady=1.
  - FIFO pointers are cleared, FSM goes to IDLE, bit and baud counters go to 0.
  - Reset asserted mid-frame aborts the frame immediately; the line returns high.
- Handshake:
  - A byte is accepted on a rising edge where DataInValid and DataInReady are both 1.
  - DataInReady = (Count != FifoDepth), derived combinationally from registered Count.
  - DataIn is sampled only on accept.
  - Pushes while full are ignored (no overwrite).
- FIFO:
  - Circular buffer with wrap-around pointers.
  - A push and a pop on the same edge are both allowed when not full; Count is unchanged.
  - When full, the push is refused even if a pop occurs on the same edge.
  - Pop when empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop the head byte into the shift register, SOut<=0, reset the baud counter, go to START. Otherwise SOut stays 1.
  - START: hold 0 for SymbolEdgeTime cycles, then SOut<=shift[0], bit index 0, go to DATA.
  - DATA: each bit is held SymbolEdgeTime cycles, then shift right. After bit 7's period, SOut<=1 and go to STOP.
  - STOP: hold 1 for SymbolEdgeTime cycles. At the end:
    - FIFO non-empty: pop and go directly to START with SOut<=0, so frames are back-to-back with no idle gap.
    - Otherwise go to IDLE.
- Timing:
  - Byte accepted at edge k into an empty FIFO with FSM IDLE: pop happens at edge k+1 and SOut falls after edge k+1.
  - Each frame lasts exactly 10*SymbolEdgeTime cycles.
- Baud counter: width $clog2(SymbolEdgeTime)+1. It counts 0..SymbolEdgeTime-1; the terminal count advances the bit.
- Busy falls the cycle after the STOP period ends with an empty FIFO.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams (IDLE/START/DATA/STOP);
  - the frame constants START_BIT=0, STOP_BIT=1, DATA_BITS=8;
  - the SymbolEdgeTime derivation helper, reused by the receiver.
- Sub-module uart_tx_fifo: a parameterised synchronous FIFO with async active-low reset, push/pop/full/empty/count. The top level contains the FSM, baud counter and shifter.

Test Plan:
- Single byte, defaults: push 0x7A after reset deasserts.
  - SOut samples taken at mid-bit every 434 cycles must read 0 | 0,1,0,1,1,1,1,0 | 1.
  - Busy falls 4340 cycles after SOut's first fall.
  - The loopback UART receiver reports DataOut=122.
- Burst: assert DataInValid continuously with bytes 0x01..0x08.
  - Exactly 5 accepted (1 shifter + 4 queued); DataInReady drops after the 5th.
  - Frames appear contiguously, with no idle high longer than the stop bit.
  - The receiver sees 0x01..0x05 in order.
- Wrap-around: repeatedly push 3, drain, push 3 for 12 bytes total (0xA0..0xAB).
  - The receiver gets all 12 in order; Count returns to 0.
- Simultaneous push/pop: FIFO holds 2 bytes; a push lands on the same edge a STOP completes and pops.
  - Count stays 2; the byte order is preserved.
- Reset mid-frame: pull Reset low during bit 3 of 0x55 with 2 bytes queued.
  - SOut=1 and Count=0 with no clock edge.
  - After release, nothing transmits until a new push.
- Parameter override: ClockFreq=1_000_000, BaudRate=100_000.
  - Each bit holds exactly 10 cycles; push 0xC3 and check the frame is 100 cycles long.
